// File: rtl/cnn_conv_acc_sat.sv
// Kernel-window accumulator: sums N_TAPS signed products plus a bias, then
// rescales with round-half-up and saturates to the signed activation width.
module cnn_conv_acc_sat #(
  parameter int PROD_W = 22,
  parameter int N_TAPS = 9,
  parameter int ACC_W  = 27,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 14
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] bias_in,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN =
    $signed({{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}});

  typedef enum logic [0:0] {S_ACC, S_OUT} state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_tap_cnt;

  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W:0]    w_sum_ext;
  logic signed [ACC_W:0]    w_r;
  logic [OUT_W-1:0]         w_out;
  logic                     w_sat;
  logic                     w_accept;
  logic                     w_last;

  assign w_prod_ext = $signed({{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data});
  assign w_bias_ext = $signed({{(ACC_W - PROD_W){bias_in[PROD_W-1]}}, bias_in});

  // First tap of a window restarts from the bias; the old sum is dropped.
  assign w_sum     = (r_tap_cnt == '0) ? (w_bias_ext + w_prod_ext) : (r_acc + w_prod_ext);
  assign w_sum_ext = {w_sum[ACC_W-1], w_sum};

  generate
    if (SHIFT == 0) begin : g_noshift
      assign w_r = w_sum_ext;
    end else begin : g_shift
      localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1) <<< (SHIFT - 1);
      assign w_r = (w_sum_ext + RND) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    w_out = w_r[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_r > SAT_MAX) begin
      w_out = SAT_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_r < SAT_MIN) begin
      w_out = SAT_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  assign prod_ready = (r_state == S_ACC);
  assign w_accept   = prod_valid && prod_ready;
  assign w_last     = (r_tap_cnt == LAST_TAP);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state   <= S_ACC;
      r_acc     <= '0;
      r_tap_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (w_last) begin
              out_data  <= w_out;
              out_sat   <= w_sat;
              out_valid <= 1'b1;
              r_tap_cnt <= '0;
              r_state   <= S_OUT;
            end else begin
              r_tap_cnt <= r_tap_cnt + CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_acc_sat.sv
// Directed bench for cnn_conv_acc_sat: default instance plus a SHIFT=0 instance.
module tb_cnn_conv_acc_sat;

  localparam int PW = 22;
  localparam int OW = 14;
  localparam int NT = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] prod_data, bias_in;
  logic          prod_valid, prod_ready;
  logic [OW-1:0] out_data;
  logic          out_sat, out_valid, out_ready;

  logic [PW-1:0] z_prod_data, z_bias_in;
  logic          z_prod_valid, z_prod_ready;
  logic [OW-1:0] z_out_data;
  logic          z_out_sat, z_out_valid, z_out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnn_conv_acc_sat dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .bias_in(bias_in),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  cnn_conv_acc_sat #(.SHIFT(0)) dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .prod_data(z_prod_data), .prod_valid(z_prod_valid), .prod_ready(z_prod_ready),
    .bias_in(z_bias_in),
    .out_data(z_out_data), .out_sat(z_out_sat), .out_valid(z_out_valid), .out_ready(z_out_ready)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One product handshake on the default instance, inputs changed #1 after an edge.
  task automatic tap(input logic signed [PW-1:0] b, input logic signed [PW-1:0] p);
    int n = 0;
    prod_valid = 1'b1;
    prod_data  = p;
    bias_in    = b;
    while (!prod_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("tap_ready", 32'(prod_ready), 1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    prod_data  = PW'($urandom);
    bias_in    = PW'($urandom);
  endtask

  task automatic window(input string tag, input logic signed [PW-1:0] b,
                        input logic signed [PW-1:0] p, input int max_gap);
    for (int i = 0; i < NT; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      if (max_gap > 0) #1;
      tap((i == 0) ? b : PW'($urandom), p);
      if (i == NT - 2) check({tag, "_valid_early"}, 32'(out_valid), 0);
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_ready_low"}, 32'(prod_ready), 0);
  endtask

  task automatic expect_out(input string tag, input int d, input logic s);
    check({tag, "_data"}, $signed(out_data), d);
    check({tag, "_sat"}, 32'(out_sat), 32'(s));
    $display("window %s: out_data=%0d out_sat=%0d", tag, $signed(out_data), out_sat);
  endtask

  // Output handshake; a product offered in the same cycle must not be taken.
  task automatic release_out(input string tag);
    out_ready  = 1'b1;
    prod_valid = 1'b1;
    prod_data  = PW'(5000);
    bias_in    = '0;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    prod_valid = 1'b0;
    check({tag, "_rel_valid"}, 32'(out_valid), 0);
    check({tag, "_rel_ready"}, 32'(prod_ready), 1);
  endtask

  task automatic window0(input string tag, input logic signed [PW-1:0] b,
                         input logic signed [PW-1:0] p, input int d, input logic s);
    for (int i = 0; i < NT; i++) begin
      z_prod_valid = 1'b1;
      z_prod_data  = p;
      z_bias_in    = (i == 0) ? b : PW'($urandom);
      @(posedge clk); #1;
    end
    z_prod_valid = 1'b0;
    check({tag, "_valid"}, 32'(z_out_valid), 1);
    check({tag, "_data"}, $signed(z_out_data), d);
    check({tag, "_sat"}, 32'(z_out_sat), 32'(s));
    $display("window %s: out_data=%0d out_sat=%0d", tag, $signed(z_out_data), z_out_sat);
    z_out_ready = 1'b1;
    @(posedge clk); #1;
    z_out_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(z_out_valid), 0);
  endtask

  initial begin
    logic [OW-1:0] held_data;
    logic          held_sat;

    rst_n = 1'b0;
    prod_valid = 1'b0; prod_data = '0; bias_in = '0; out_ready = 1'b0;
    z_prod_valid = 1'b0; z_prod_data = '0; z_bias_in = '0; z_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", $signed(out_data), 0);
    check("rst_sat", 32'(out_sat), 0);
    check("rst_ready", 32'(prod_ready), 1);
    $display("reset: out_valid=%0d prod_ready=%0d", out_valid, prod_ready);
    rst_n = 1'b1;

    // Nominal: 9 x 64 -> 576 -> 9
    window("nominal", 0, 64, 0);
    expect_out("nominal", 9, 1'b0);
    release_out("nominal");

    // Round half up on negative sums
    window("neg_round", -160, 8, 0);
    expect_out("neg_round", -1, 1'b0);
    release_out("neg_round");
    window("neg_half", -128, 0, 0);
    expect_out("neg_half", -2, 1'b0);
    release_out("neg_half");

    // Saturation at both rails
    window("sat_pos", 0, 2097151, 0);
    expect_out("sat_pos", 8191, 1'b1);
    release_out("sat_pos");
    window("sat_neg", -2097152, -2097152, 0);
    expect_out("sat_neg", -8192, 1'b1);
    release_out("sat_neg");

    // Valid gaps mid-window do not change the result
    window("gaps", 0, 64, 3);
    expect_out("gaps", 9, 1'b0);

    // Hold out_ready low for 5 cycles while products are offered
    held_data = out_data;
    held_sat  = out_sat;
    for (int c = 0; c < 5; c++) begin
      prod_valid = 1'b1;
      prod_data  = PW'(7777);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", $signed(out_data), $signed(held_data));
      check("hold_sat", 32'(out_sat), 32'(held_sat));
      check("hold_ready", 32'(prod_ready), 0);
    end
    prod_valid = 1'b0;
    release_out("hold");

    // Window right after release: 1000 + 9*64 = 1576 -> (1576+32)>>>6 = 25
    window("after_rel", 1000, 64, 0);
    expect_out("after_rel", 25, 1'b0);
    release_out("after_rel");

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 4; i++) tap((i == 0) ? PW'(0) : PW'($urandom), 1000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ready", 32'(prod_ready), 1);
    window("post_rst", 0, 64, 0);
    expect_out("post_rst", 9, 1'b0);

    // Reset while the result is held
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("outrst_valid", 32'(out_valid), 0);
    check("outrst_data", $signed(out_data), 0);
    check("outrst_sat", 32'(out_sat), 0);
    check("outrst_ready", 32'(prod_ready), 1);
    $display("reset in OUT: out_valid=%0d out_data=%0d", out_valid, $signed(out_data));

    // SHIFT=0 instance: no rounding term
    window0("shift0", 5, 1, 14, 1'b0);
    window0("shift0_neg", -10, -1, -19, 1'b0);
    window0("shift0_sat", 8000, 100, 8191, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
